wbus_xfer_sequencer: RTL and testbench

- Sequences register-to-register transfers over the write bus.
- Drives the raw active-low read/write select lines (RA_n..RU_n, WA_n..WY_n) and the RT_n/WT_n/CT_n timing strobes that the service-gate logic decodes into register gate pulses.
- Arbitrates two requesters: the main sequence, which is queued, and the counter-increment cycle-steal path, which has priority.
- Guarantees that every transfer follows a fixed select/clear/transfer/hold slot.

---
 rtl/wbus_xfer_sequencer.sv | 178 +++++++++++++++++
 tb/tb_wbus_xfer_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wbus_xfer_sequencer.sv
// Write-bus transfer sequencer: arbitrates queued main requests against counter steals and
// drives the select/clear/transfer/hold slot. Optional macro: WBUS_STEAL_LIMIT_EN.
module wbus_xfer_sequencer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int MAX_STEAL   = 3
) (
    input  logic       SIM_CLK,
    input  logic       SIM_RST,
    input  logic       seq_valid,
    input  logic [2:0] seq_src,
    input  logic [2:0] seq_dst,
    output logic       seq_ready,
    output logic       seq_err,
    output logic       seq_done,
    input  logic       cnt_req,
    input  logic [2:0] cnt_src,
    input  logic [2:0] cnt_dst,
    output logic       cnt_done,
    output logic       RA_n, RB_n, RG_n, RL_n, RQ_n, RZ_n, RU_n,
    output logic       WA_n, WB_n, WG_n, WL_n, WQ_n, WZ_n, WY_n,
    output logic       RT_n, WT_n, CT_n,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, SEL, CLR, XFER, HOLD} state_t;

    function automatic logic [6:0] sel_n(input logic [2:0] code);
        logic [6:0] v;
        v = '1;
        if (code != 3'd0) v[code - 3'd1] = 1'b0;
        return v;
    endfunction

    state_t      state_q;
    logic [1:0]  hold_q;
    logic        owner_cnt_q;
    logic [6:0]  rsel_q, wsel_q;
    logic        rt_q, wt_q, ct_q, busy_q;
    logic        seq_done_q, cnt_done_q, seq_err_q;
    logic [2:0]  cur_src_q, cur_dst_q;

    logic [2:0]  fsrc_q [DEPTH];
    logic [2:0]  fdst_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] count_q;

    logic empty, full, bad_code, push_ok, last_hold, arb_pt, force_main;
    logic grant_cnt, grant_main, grant, pop, do_push, done_now;
    logic [2:0] g_src, g_dst;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign bad_code  = (seq_src != 3'd0) && (seq_src == seq_dst);
    assign push_ok   = seq_valid && !full && !bad_code;
    assign last_hold = (state_q == HOLD) && (hold_q == 2'(HOLD_CYCLES - 1));
    assign arb_pt    = (state_q == IDLE) || last_hold;

    // An empty FIFO lets a fresh request bypass the queue and start the next cycle
    assign grant_cnt  = arb_pt && cnt_req && !force_main;
    assign grant_main = arb_pt && (!empty || push_ok) && !grant_cnt;
    assign grant      = grant_cnt || grant_main;
    assign pop        = grant_main && !empty;
    assign do_push    = push_ok && !(grant_main && empty);
    assign g_src      = grant_cnt ? cnt_src : (empty ? seq_src : fsrc_q[rd_q]);
    assign g_dst      = grant_cnt ? cnt_dst : (empty ? seq_dst : fdst_q[rd_q]);
    assign done_now   = (state_q == XFER && HOLD_CYCLES == 1) ||
                        (state_q == HOLD && !last_hold && hold_q == 2'(HOLD_CYCLES - 2));

`ifdef WBUS_STEAL_LIMIT_EN
    localparam int SW = $clog2(MAX_STEAL + 1) + 1;
    logic [SW-1:0] steal_q;
    assign force_main = (steal_q == SW'(MAX_STEAL)) && !empty;

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST)                                     steal_q <= '0;
        else if (grant_main)                             steal_q <= '0;
        else if (grant_cnt && steal_q != SW'(MAX_STEAL)) steal_q <= steal_q + SW'(1);
    end
`else
    // MAX_STEAL is never negative, so main is never forced ahead of a steal
    assign force_main = (MAX_STEAL < 0);
`endif

    always_ff @(posedge SIM_CLK) begin
        if (do_push) begin
            fsrc_q[wr_q] <= seq_src;
            fdst_q[wr_q] <= seq_dst;
        end
        if (grant) begin
            cur_src_q <= g_src;
            cur_dst_q <= g_dst;
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (pop)     rd_q <= rd_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            owner_cnt_q <= 1'b0;
            rsel_q      <= '1;
            wsel_q      <= '1;
            rt_q        <= 1'b1;
            wt_q        <= 1'b1;
            ct_q        <= 1'b1;
            busy_q      <= 1'b0;
            seq_done_q  <= 1'b0;
            cnt_done_q  <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            seq_done_q <= done_now && !owner_cnt_q;
            cnt_done_q <= done_now && owner_cnt_q;
            seq_err_q  <= seq_valid && !full && bad_code;
            if (grant) begin
                state_q     <= SEL;
                busy_q      <= 1'b1;
                owner_cnt_q <= grant_cnt;
                rsel_q      <= sel_n(g_src);
                wsel_q      <= sel_n(g_dst);
            end else begin
                unique case (state_q)
                    IDLE: ;
                    SEL: begin
                        state_q <= CLR;
                        ct_q    <= (cur_dst_q == 3'd0);
                    end
                    CLR: begin
                        state_q <= XFER;
                        ct_q    <= 1'b1;
                        rt_q    <= (cur_src_q == 3'd0);
                        wt_q    <= (cur_dst_q == 3'd0);
                    end
                    XFER: begin
                        state_q <= HOLD;
                        rt_q    <= 1'b1;
                        wt_q    <= 1'b1;
                        hold_q  <= '0;
                    end
                    HOLD: begin
                        if (last_hold) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            rsel_q  <= '1;
                            wsel_q  <= '1;
                        end else begin
                            hold_q <= hold_q + 2'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign seq_ready = !full;
    assign seq_err   = seq_err_q;
    assign seq_done  = seq_done_q;
    assign cnt_done  = cnt_done_q;
    assign busy      = busy_q;
    assign RT_n = rt_q;
    assign WT_n = wt_q;
    assign CT_n = ct_q;
    assign {RU_n, RZ_n, RQ_n, RL_n, RG_n, RB_n, RA_n} = rsel_q;
    assign {WY_n, WZ_n, WQ_n, WL_n, WG_n, WB_n, WA_n} = wsel_q;
endmodule

// File: tb/tb_wbus_xfer_sequencer.sv
// Directed bench for wbus_xfer_sequencer: vector table plus multi-cycle corner sequences.
module tb_wbus_xfer_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, seq_valid, cnt_req;
    logic [2:0] seq_src, seq_dst, cnt_src, cnt_dst;
    logic       seq_ready, seq_err, seq_done, cnt_done, busy;
    logic [6:0] rs, ws;
    logic       rt, wt, ct;

    logic       h_valid, h_creq;
    logic [2:0] h_src, h_dst, h_csrc, h_cdst;
    logic       h_ready, h_err, h_sdone, h_cdone, h_busy;
    logic [6:0] hrs, hws;
    logic       hrt, hwt, hct;

    int total = 0;
    int bad   = 0;

    wbus_xfer_sequencer #(.DEPTH(4), .HOLD_CYCLES(1), .MAX_STEAL(3)) dut (
        .SIM_CLK(clk), .SIM_RST(rst),
        .seq_valid(seq_valid), .seq_src(seq_src), .seq_dst(seq_dst),
        .seq_ready(seq_ready), .seq_err(seq_err), .seq_done(seq_done),
        .cnt_req(cnt_req), .cnt_src(cnt_src), .cnt_dst(cnt_dst), .cnt_done(cnt_done),
        .RA_n(rs[0]), .RB_n(rs[1]), .RG_n(rs[2]), .RL_n(rs[3]), .RQ_n(rs[4]), .RZ_n(rs[5]), .RU_n(rs[6]),
        .WA_n(ws[0]), .WB_n(ws[1]), .WG_n(ws[2]), .WL_n(ws[3]), .WQ_n(ws[4]), .WZ_n(ws[5]), .WY_n(ws[6]),
        .RT_n(rt), .WT_n(wt), .CT_n(ct), .busy(busy)
    );

    wbus_xfer_sequencer #(.DEPTH(4), .HOLD_CYCLES(3), .MAX_STEAL(3)) dut3 (
        .SIM_CLK(clk), .SIM_RST(rst),
        .seq_valid(h_valid), .seq_src(h_src), .seq_dst(h_dst),
        .seq_ready(h_ready), .seq_err(h_err), .seq_done(h_sdone),
        .cnt_req(h_creq), .cnt_src(h_csrc), .cnt_dst(h_cdst), .cnt_done(h_cdone),
        .RA_n(hrs[0]), .RB_n(hrs[1]), .RG_n(hrs[2]), .RL_n(hrs[3]), .RQ_n(hrs[4]), .RZ_n(hrs[5]), .RU_n(hrs[6]),
        .WA_n(hws[0]), .WB_n(hws[1]), .WG_n(hws[2]), .WL_n(hws[3]), .WQ_n(hws[4]), .WZ_n(hws[5]), .WY_n(hws[6]),
        .RT_n(hrt), .WT_n(hwt), .CT_n(hct), .busy(h_busy)
    );

    typedef struct {
        logic       rst, sv;
        logic [2:0] ss, sd;
        logic       cr;
        logic [2:0] cs, cd;
        logic [6:0] er, ew;
        logic [2:0] est;
        logic       eb, esd, ecd, ee, ery;
        string      nm;
    } vec_t;

    vec_t tv [18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {10'd0, rs, ws, rt, wt, ct, busy, seq_done, cnt_done, seq_err, seq_ready};
    endfunction

    function automatic logic [6:0] sel(input int code);
        logic [6:0] v;
        v = '1;
        if (code != 0) v[code-1] = 1'b0;
        return v;
    endfunction

    logic [31:0] exp_w;
    logic [7:0]  pat, exp_pat;
    logic [6:0]  e_rs;
    int n, gap, seen;

    initial begin
        rst = 1'b1; seq_valid = 0; seq_src = 0; seq_dst = 0;
        cnt_req = 0; cnt_src = 0; cnt_dst = 0;
        h_valid = 0; h_src = 0; h_dst = 0; h_creq = 0; h_csrc = 0; h_cdst = 0;

        //          rst sv ss dd cr cs cd  er     ew     RT/WT/CT busy sd cd err rdy
        tv[0]  = '{1, 0, 0, 0, 0, 0, 0, 7'h7F, 7'h7F, 3'b111, 0, 0, 0, 0, 1, "reset"};
        tv[1]  = '{0, 1, 2, 1, 0, 0, 0, 7'h7D, 7'h7E, 3'b111, 1, 0, 0, 0, 1, "ba_sel"};
        tv[2]  = '{0, 0, 0, 0, 0, 0, 0, 7'h7D, 7'h7E, 3'b110, 1, 0, 0, 0, 1, "ba_clr"};
        tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 7'h7D, 7'h7E, 3'b001, 1, 0, 0, 0, 1, "ba_xfer"};
        tv[4]  = '{0, 0, 0, 0, 0, 0, 0, 7'h7D, 7'h7E, 3'b111, 1, 1, 0, 0, 1, "ba_hold"};
        tv[5]  = '{0, 0, 0, 0, 0, 0, 0, 7'h7F, 7'h7F, 3'b111, 0, 0, 0, 0, 1, "ba_idle"};
        tv[6]  = '{0, 1, 3, 3, 0, 0, 0, 7'h7F, 7'h7F, 3'b111, 0, 0, 0, 1, 1, "gg_err"};
        tv[7]  = '{0, 0, 0, 0, 0, 0, 0, 7'h7F, 7'h7F, 3'b111, 0, 0, 0, 0, 1, "gg_none"};
        tv[8]  = '{0, 1, 0, 6, 0, 0, 0, 7'h7F, 7'h5F, 3'b111, 1, 0, 0, 0, 1, "0z_sel"};
        tv[9]  = '{0, 0, 0, 0, 0, 0, 0, 7'h7F, 7'h5F, 3'b110, 1, 0, 0, 0, 1, "0z_clr"};
        tv[10] = '{0, 0, 0, 0, 0, 0, 0, 7'h7F, 7'h5F, 3'b101, 1, 0, 0, 0, 1, "0z_xfer"};
        tv[11] = '{0, 0, 0, 0, 0, 0, 0, 7'h7F, 7'h5F, 3'b111, 1, 1, 0, 0, 1, "0z_hold"};
        tv[12] = '{0, 0, 0, 0, 0, 0, 0, 7'h7F, 7'h7F, 3'b111, 0, 0, 0, 0, 1, "0z_idle"};
        tv[13] = '{0, 0, 0, 0, 1, 7, 7, 7'h3F, 7'h3F, 3'b111, 1, 0, 0, 0, 1, "uy_sel"};
        tv[14] = '{0, 0, 0, 0, 0, 0, 0, 7'h3F, 7'h3F, 3'b110, 1, 0, 0, 0, 1, "uy_clr"};
        tv[15] = '{0, 0, 0, 0, 0, 0, 0, 7'h3F, 7'h3F, 3'b001, 1, 0, 0, 0, 1, "uy_xfer"};
        tv[16] = '{0, 0, 0, 0, 0, 0, 0, 7'h3F, 7'h3F, 3'b111, 1, 0, 1, 0, 1, "uy_hold"};
        tv[17] = '{0, 0, 0, 0, 0, 0, 0, 7'h7F, 7'h7F, 3'b111, 0, 0, 0, 0, 1, "uy_idle"};

        for (int i = 0; i < 18; i++) begin
            rst = tv[i].rst; seq_valid = tv[i].sv; seq_src = tv[i].ss; seq_dst = tv[i].sd;
            cnt_req = tv[i].cr; cnt_src = tv[i].cs; cnt_dst = tv[i].cd;
            tick();
            exp_w = {10'd0, tv[i].er, tv[i].ew, tv[i].est, tv[i].eb, tv[i].esd,
                     tv[i].ecd, tv[i].ee, tv[i].ery};
            check(tv[i].nm, outs(), exp_w);
        end

        // Fill the FIFO while a steal holds the bus, then drain back-to-back
        cnt_req = 1; cnt_src = 1; cnt_dst = 2;
        tick();
        seq_valid = 1;
        for (int k = 1; k <= 5; k++) begin
            seq_src = 3'(k); seq_dst = 3'd7;
            tick();
            if (k == 4) check("fill_ready4", 32'(seq_ready), 32'd0);
        end
        seq_valid = 0;
        check("fill_ready5", 32'(seq_ready), 32'd0);
        seen = 0;
        for (int c = 0; c < 12 && seen == 0; c++) begin
            if (cnt_done) seen = 1;
            else tick();
        end
        check("fill_cnt_done", 32'(seen), 32'd1);
        cnt_req = 0;
        n = 0; gap = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (n < 4 && !busy) gap++;
            if (seq_done) begin
                e_rs = sel(n + 1);
                if (n < 4) check("fill_order", 32'(rs), 32'(e_rs));
                n++;
            end
        end
        check("fill_count", 32'(n), 32'd4);
        check("fill_b2b", 32'(gap), 32'd0);

        // Steal priority with two queued main requests
        rst = 1; tick(); rst = 0;
        cnt_req = 1; cnt_src = 4; cnt_dst = 5;
        seq_valid = 1; seq_src = 1; seq_dst = 2;
        tick();
        seq_src = 3; seq_dst = 4;
        tick();
        seq_valid = 0;
        n = 0; pat = '0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            tick();
            if (seq_done) begin pat[n] = 1'b1; n++; end
            else if (cnt_done) begin pat[n] = 1'b0; n++; end
        end
`ifdef WBUS_STEAL_LIMIT_EN
        exp_pat = 8'b1000_1000;
`else
        exp_pat = 8'b0000_0000;
`endif
        check("prio_events", 32'(n), 32'd8);
        check("prio_pattern", 32'(pat), 32'(exp_pat));
        cnt_req = 0;

        // Reset during XFER aborts the slot and flushes the queue
        rst = 1; tick(); rst = 0;
        seq_valid = 1; seq_src = 6; seq_dst = 3;
        tick();
        e_rs = sel(6);
        check("rst_sel", 32'({rs, ws}), 32'({e_rs, sel(3)}));
        seq_src = 2; seq_dst = 1;
        tick();
        seq_valid = 0;
        tick();
        check("rst_xfer", 32'({rt, wt, ct}), 32'b001);
        rst = 1;
        tick();
        check("rst_mid", outs(), {10'd0, 7'h7F, 7'h7F, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        rst = 0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (busy || seq_done || !seq_ready) n++;
        end
        check("rst_flush", 32'(n), 32'd0);

        // HOLD_CYCLES = 3 instance: Q -> L
        h_valid = 1; h_src = 5; h_dst = 4;
        tick();
        h_valid = 0;
        for (int s = 0; s < 7; s++) begin
            logic [31:0] act, exp;
            act = {9'd0, hrs, hws, hrt, hwt, hct, h_busy, h_sdone, h_cdone};
            case (s)
                0: exp = {9'd0, 7'h6F, 7'h77, 3'b111, 1'b1, 1'b0, 1'b0};
                1: exp = {9'd0, 7'h6F, 7'h77, 3'b110, 1'b1, 1'b0, 1'b0};
                2: exp = {9'd0, 7'h6F, 7'h77, 3'b001, 1'b1, 1'b0, 1'b0};
                3: exp = {9'd0, 7'h6F, 7'h77, 3'b111, 1'b1, 1'b0, 1'b0};
                4: exp = {9'd0, 7'h6F, 7'h77, 3'b111, 1'b1, 1'b0, 1'b0};
                5: exp = {9'd0, 7'h6F, 7'h77, 3'b111, 1'b1, 1'b1, 1'b0};
                default: exp = {9'd0, 7'h7F, 7'h7F, 3'b111, 1'b0, 1'b0, 1'b0};
            endcase
            check($sformatf("hold3_s%0d", s), act, exp);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
